// File: rtl/life_grid_engine_if.sv
// Control and status bundle for life_grid_engine: run/step/load controls in,
// grid state and generation status out.
interface life_grid_engine_if #(
    parameter int ROWS  = 5,
    parameter int COLS  = 5,
    parameter int GEN_W = 16
);
    localparam int N = ROWS * COLS;

    logic             run;
    logic             step_req;
    logic             load;
    logic [N-1:0]     init_cells;
    logic [N-1:0]     cells;
    logic [GEN_W-1:0] generation;
    logic             step_done;
    logic             stable;
    logic             extinct;
    logic [1:0]       mode;

    // Controller side: owns the pattern source and run controls.
    modport master (
        output run, step_req, load, init_cells,
        input  cells, generation, step_done, stable, extinct, mode
    );

    // Engine side.
    modport slave (
        input  run, step_req, load, init_cells,
        output cells, generation, step_done, stable, extinct, mode
    );
endinterface

// File: rtl/life_grid_engine.sv
// Parametrised Game-of-Life core (B3/S23) with step divider, run/pause/step/load
// control and auto-halt. Define LIFE_TOROIDAL_EN for wrapping edges; default is a dead border.
module life_grid_engine #(
    parameter int ROWS      = 5,
    parameter int COLS      = 5,
    parameter int TICK_DIV  = 8388608,
    parameter int GEN_W     = 16,
    parameter int AUTO_HALT = 1
) (
    input  logic             clk,
    input  logic             rst,
    life_grid_engine_if.slave bus
);
    localparam int N      = ROWS * COLS;
    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        PAUSED  = 2'd0,
        RUNNING = 2'd1,
        HALTED  = 2'd2
    } mode_e;

    generate
        if (ROWS < 3 || COLS < 3 || TICK_DIV < 1) begin : g_param_err
            $error("life_grid_engine: ROWS and COLS must be >= 3 and TICK_DIV >= 1");
        end
    endgenerate

    mode_e              state_q, state_d;
    logic [N-1:0]       cells_q;
    logic [N-1:0]       next_cells;
    logic [GEN_W-1:0]   gen_q;
    logic [TICK_W-1:0]  tick_q;
    logic               step_q;
    logic               step_done_q;
    logic               stable_q;
    logic               step_edge;
    logic               tick_hit;
    logic               step_commit;
    logic               next_quiet;

    // Next-generation logic: one neighbour counter per cell, fed only from cells_q.
    generate
        for (genvar r = 0; r < ROWS; r++) begin : g_row
            for (genvar c = 0; c < COLS; c++) begin : g_col
                logic [8:0] nb;
                logic [3:0] cnt;

                for (genvar dr = 0; dr < 3; dr++) begin : g_dr
                    for (genvar dc = 0; dc < 3; dc++) begin : g_dc
                        localparam int NR = r + dr - 1;
                        localparam int NC = c + dc - 1;
                        if (dr == 1 && dc == 1) begin : g_self
                            assign nb[3*dr+dc] = 1'b0;
                        end else begin : g_nb
`ifdef LIFE_TOROIDAL_EN
                            localparam int WR = (NR + ROWS) % ROWS;
                            localparam int WC = (NC + COLS) % COLS;
                            assign nb[3*dr+dc] = cells_q[COLS*WR + WC];
`else
                            if (NR >= 0 && NR < ROWS && NC >= 0 && NC < COLS) begin : g_in
                                assign nb[3*dr+dc] = cells_q[COLS*NR + NC];
                            end else begin : g_border
                                assign nb[3*dr+dc] = 1'b0;
                            end
`endif
                        end
                    end
                end

                // NOTE: combinational blocks assign a default before any conditional update so no latch is inferred.
                always_comb begin
                    cnt = '0;
                    for (int k = 0; k < 9; k++) begin
                        cnt = cnt + {3'b000, nb[k]};
                    end
                end

                assign next_cells[COLS*r + c] = (cnt == 4'd3) | (cells_q[COLS*r + c] & (cnt == 4'd2));
            end
        end
    endgenerate

    assign step_edge  = bus.step_req & ~step_q;
    assign tick_hit   = (tick_q == TICK_MAX);
    assign next_quiet = (next_cells == cells_q) || (next_cells == '0);

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= PAUSED;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.load) begin
            state_d = PAUSED;
        end else begin
            case (state_q)
                PAUSED: begin
                    if (bus.run) state_d = RUNNING;
                end
                RUNNING: begin
                    if (!bus.run) begin
                        state_d = PAUSED;
                    end else if (tick_hit && (AUTO_HALT != 0) && next_quiet) begin
                        state_d = HALTED;
                    end
                end
                HALTED: begin
                    if (!bus.run) state_d = PAUSED;
                end
                default: state_d = PAUSED;
            endcase
        end
    end

    // A step is either a single-step edge while paused or a divider hit while running; load discards it.
    always_comb begin
        step_commit = 1'b0;
        if (!bus.load) begin
            case (state_q)
                PAUSED:  step_commit = step_edge;
                RUNNING: step_commit = bus.run && tick_hit;
                default: step_commit = 1'b0;
            endcase
        end
    end

    // NOTE: the cell array is a flat register file that must come out of reset empty, so it is reset like any other state.
    always_ff @(posedge clk) begin
        if (rst) begin
            cells_q     <= '0;
            gen_q       <= '0;
            stable_q    <= 1'b0;
            tick_q      <= '0;
            step_q      <= 1'b0;
            step_done_q <= 1'b0;
        end else begin
            step_q      <= bus.step_req;
            step_done_q <= step_commit;

            if (bus.load) begin
                cells_q  <= bus.init_cells;
                gen_q    <= '0;
                stable_q <= 1'b0;
                tick_q   <= '0;
            end else begin
                if (step_commit) begin
                    cells_q  <= next_cells;
                    gen_q    <= (gen_q == '1) ? gen_q : gen_q + GEN_W'(1);
                    stable_q <= (next_cells == cells_q);
                end
                // Counter only advances while staying in RUNNING, so it is 0 on every entry.
                if (state_q == RUNNING && state_d == RUNNING) begin
                    tick_q <= tick_hit ? '0 : tick_q + TICK_W'(1);
                end else begin
                    tick_q <= '0;
                end
            end
        end
    end

    assign bus.cells      = cells_q;
    assign bus.generation = gen_q;
    assign bus.step_done  = step_done_q;
    assign bus.stable     = stable_q;
    assign bus.extinct    = (cells_q == '0);
    assign bus.mode       = state_q;

endmodule

// File: tb/tb_life_grid_engine.sv
// Scoreboard bench for life_grid_engine: three 5x5 instances cover the single-step,
// divided still-life, extinction and non-halting blinker cases.
module tb_life_grid_engine;
    localparam int N = 25;

    localparam logic [N-1:0] P_H    = 25'h0003800; // bits 11,12,13
    localparam logic [N-1:0] P_V    = 25'h0021080; // bits 7,12,17
    localparam logic [N-1:0] P_BLK  = 25'h00018C0; // bits 6,7,11,12
    localparam logic [N-1:0] P_ONE  = 25'h0001000; // bit 12
    localparam logic [N-1:0] P_ROW0 = 25'h000000E; // bits 1,2,3
`ifdef LIFE_TOROIDAL_EN
    localparam logic [N-1:0] P_EDGE = 25'h0400084; // bits 2,7,22
`else
    localparam logic [N-1:0] P_EDGE = 25'h0000084; // bits 2,7
`endif

    typedef struct packed {
        logic [N-1:0] cells;
        logic [15:0]  gen;
        logic         stable;
        logic [1:0]   mode;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];

    always #5 clk = ~clk;

    life_grid_engine_if #(.ROWS(5), .COLS(5), .GEN_W(16)) bus_a ();
    life_grid_engine_if #(.ROWS(5), .COLS(5), .GEN_W(16)) bus_b ();
    life_grid_engine_if #(.ROWS(5), .COLS(5), .GEN_W(16)) bus_c ();

    life_grid_engine #(.ROWS(5), .COLS(5), .TICK_DIV(1), .GEN_W(16), .AUTO_HALT(1))
        u_a (.clk(clk), .rst(rst), .bus(bus_a));
    life_grid_engine #(.ROWS(5), .COLS(5), .TICK_DIV(4), .GEN_W(16), .AUTO_HALT(1))
        u_b (.clk(clk), .rst(rst), .bus(bus_b));
    life_grid_engine #(.ROWS(5), .COLS(5), .TICK_DIV(1), .GEN_W(16), .AUTO_HALT(0))
        u_c (.clk(clk), .rst(rst), .bus(bus_c));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic compare_step(input string tag, input exp_t e, input logic [N-1:0] cells,
                                input logic [15:0] gen, input logic stable, input logic [1:0] mode);
        check({tag, "_step_cells"},  32'(cells),  32'(e.cells));
        check({tag, "_step_gen"},    32'(gen),    32'(e.gen));
        check({tag, "_step_stable"}, 32'(stable), 32'(e.stable));
        check({tag, "_step_mode"},   32'(mode),   32'(e.mode));
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitors: every step_done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (bus_a.step_done === 1'b1) begin
            if (q_a.size() == 0) begin
                checks++; failures++;
                $display("FAIL a_unexpected_step: got step_done=1 at gen %0d, expected none", bus_a.generation);
            end else compare_step("a", q_a.pop_front(), bus_a.cells, bus_a.generation, bus_a.stable, bus_a.mode);
        end
    end

    always @(negedge clk) begin
        if (bus_b.step_done === 1'b1) begin
            if (q_b.size() == 0) begin
                checks++; failures++;
                $display("FAIL b_unexpected_step: got step_done=1 at gen %0d, expected none", bus_b.generation);
            end else compare_step("b", q_b.pop_front(), bus_b.cells, bus_b.generation, bus_b.stable, bus_b.mode);
        end
    end

    always @(negedge clk) begin
        if (bus_c.step_done === 1'b1) begin
            if (q_c.size() == 0) begin
                checks++; failures++;
                $display("FAIL c_unexpected_step: got step_done=1 at gen %0d, expected none", bus_c.generation);
            end else compare_step("c", q_c.pop_front(), bus_c.cells, bus_c.generation, bus_c.stable, bus_c.mode);
        end
    end

    initial begin
        bus_a.run = 1'b0; bus_a.step_req = 1'b0; bus_a.load = 1'b0; bus_a.init_cells = '0;
        bus_b.run = 1'b0; bus_b.step_req = 1'b0; bus_b.load = 1'b0; bus_b.init_cells = '0;
        bus_c.run = 1'b0; bus_c.step_req = 1'b0; bus_c.load = 1'b0; bus_c.init_cells = '0;

        // Reset held for two edges.
        cyc(2);
        check("rst_cells",     32'(bus_a.cells), 32'h0);
        check("rst_gen",       32'(bus_a.generation), 32'h0);
        check("rst_mode",      32'(bus_a.mode), 32'h0);
        check("rst_step_done", 32'(bus_a.step_done), 32'h0);
        check("rst_stable",    32'(bus_a.stable), 32'h0);
        check("rst_extinct",   32'(bus_a.extinct), 32'h1);
        check("rst_mode_b",    32'(bus_b.mode), 32'h0);
        rst = 1'b0;
        cyc(1);

        // Single step of a horizontal blinker, then step_req held high.
        bus_a.init_cells = P_H; bus_a.load = 1'b1;
        cyc(1);
        bus_a.load = 1'b0;
        check("load_cells",   32'(bus_a.cells), 32'(P_H));
        check("load_extinct", 32'(bus_a.extinct), 32'h0);
        bus_a.step_req = 1'b1;
        q_a.push_back('{cells: P_V, gen: 16'd1, stable: 1'b0, mode: 2'd0});
        cyc(11);
        check("held_req_cells", 32'(bus_a.cells), 32'(P_V));
        check("held_req_gen",   32'(bus_a.generation), 32'd1);
        bus_a.step_req = 1'b0;
        cyc(1);

        // Edge handling on row 0.
        bus_a.init_cells = P_ROW0; bus_a.load = 1'b1;
        cyc(1);
        bus_a.load = 1'b0; bus_a.step_req = 1'b1;
        q_a.push_back('{cells: P_EDGE, gen: 16'd1, stable: 1'b0, mode: 2'd0});
        cyc(1);
        bus_a.step_req = 1'b0;
        check("edge_cells", 32'(bus_a.cells), 32'(P_EDGE));
        cyc(2);

        // Empty load: extinct at once, no halt without a step.
        bus_a.init_cells = '0; bus_a.load = 1'b1;
        cyc(1);
        bus_a.load = 1'b0;
        check("zero_load_extinct", 32'(bus_a.extinct), 32'h1);
        cyc(3);
        check("zero_load_mode", 32'(bus_a.mode), 32'h0);

        // Extinction with TICK_DIV = 1.
        bus_a.init_cells = P_ONE; bus_a.load = 1'b1;
        cyc(1);
        bus_a.load = 1'b0; bus_a.run = 1'b1;
        q_a.push_back('{cells: '0, gen: 16'd1, stable: 1'b0, mode: 2'd2});
        cyc(1);
        check("ext_running", 32'(bus_a.mode), 32'h1);
        cyc(1);
        check("ext_mode",    32'(bus_a.mode), 32'h2);
        check("ext_extinct", 32'(bus_a.extinct), 32'h1);
        cyc(3);
        bus_a.step_req = 1'b1;
        cyc(1);
        bus_a.step_req = 1'b0;
        cyc(2);
        check("halted_ignores_req", 32'(bus_a.generation), 32'd1);
        bus_a.run = 1'b0;
        cyc(1);
        check("halt_to_paused", 32'(bus_a.mode), 32'h0);

        // Still life with TICK_DIV = 4.
        bus_b.init_cells = P_BLK; bus_b.load = 1'b1;
        cyc(1);
        bus_b.load = 1'b0; bus_b.run = 1'b1;
        q_b.push_back('{cells: P_BLK, gen: 16'd1, stable: 1'b1, mode: 2'd2});
        cyc(4);
        check("div_no_step_yet", 32'(bus_b.generation), 32'd0);
        check("div_running",     32'(bus_b.mode), 32'h1);
        cyc(1);
        check("still_gen",    32'(bus_b.generation), 32'd1);
        check("still_mode",   32'(bus_b.mode), 32'h2);
        check("still_stable", 32'(bus_b.stable), 32'h1);
        cyc(10);
        check("still_no_more", 32'(bus_b.generation), 32'd1);
        bus_b.run = 1'b0;
        cyc(1);

        // Blinker, AUTO_HALT = 0: six steps then pause.
        bus_c.init_cells = P_H; bus_c.load = 1'b1;
        cyc(1);
        bus_c.load = 1'b0; bus_c.run = 1'b1;
        for (int g = 1; g <= 6; g++) begin
            q_c.push_back('{cells: (g % 2 == 1) ? P_V : P_H, gen: 16'(g), stable: 1'b0, mode: 2'd1});
        end
        cyc(7);
        bus_c.run = 1'b0;
        check("blink_gen",   32'(bus_c.generation), 32'd6);
        check("blink_cells", 32'(bus_c.cells), 32'(P_H));
        cyc(1);
        check("blink_paused", 32'(bus_c.mode), 32'h0);

        // Load during a run discards the step due that cycle.
        bus_c.run = 1'b1;
        q_c.push_back('{cells: P_V, gen: 16'd7, stable: 1'b0, mode: 2'd1});
        q_c.push_back('{cells: P_H, gen: 16'd8, stable: 1'b0, mode: 2'd1});
        cyc(3);
        bus_c.init_cells = P_V; bus_c.load = 1'b1;
        cyc(1);
        bus_c.load = 1'b0; bus_c.run = 1'b0;
        check("reload_gen",       32'(bus_c.generation), 32'd0);
        check("reload_mode",      32'(bus_c.mode), 32'h0);
        check("reload_cells",     32'(bus_c.cells), 32'(P_V));
        check("reload_step_done", 32'(bus_c.step_done), 32'h0);
        cyc(3);

        check("pending_a", 32'(q_a.size()), 32'd0);
        check("pending_b", 32'(q_b.size()), 32'd0);
        check("pending_c", 32'(q_c.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/life_grid_engine.md
Name: life_grid_engine

Overview:
- Parametrised Conway Game-of-Life core: ROWS x COLS cell register array with B3/S23 update, built-in step divider, and run/pause/single-step/load control.
- Reports generation count, still-life detection and extinction, and halts automatically when the pattern stops evolving.
- Sits between the initial-condition source and the LED array driver; replaces the fixed-size dead-border grid and its top-level divider logic.

Parameters:
- ROWS, 5, grid height; must be >= 3.
- COLS, 5, grid width; must be >= 3.
- TICK_DIV, 8388608, clock cycles per automatic step while running; must be >= 1.
- GEN_W, 16, generation counter width.
- AUTO_HALT, 1, 1 = enter HALTED on a still or extinct result; 0 = keep running.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- run  in  1  level; 1 = free-run, 0 = pause.
- step_req  in  1  single-step request; rising edge only, honoured in PAUSED.
- load  in  1  1-cycle strobe; copies init_cells into the grid.
- init_cells  in  ROWS*COLS  initial pattern; bit index = COLS*row + col, bit 0 = bottom-left.
- cells  out  ROWS*COLS  current grid state, registered, same indexing.
- generation  out  GEN_W  steps since last load or reset; saturates at all-ones.
- step_done  out  1  1-cycle pulse in the cycle after a step commits.
- stable  out  1  registered; 1 if the last step produced no change.
- extinct  out  1  combinational; 1 when cells == 0.
- mode  out  2  0 = PAUSED, 1 = RUNNING, 2 = HALTED.

Behaviour:
- Reset values: cells = 0, generation = 0, step_done = 0, stable = 0, mode = PAUSED, tick counter = 0, step_req edge register = 0.
- Priority: rst > load > step.
- load: cells <= init_cells, generation <= 0, stable <= 0, tick counter <= 0, mode <= PAUSED, in any state. A step due in the same cycle is discarded.
- Next-state rule per cell: count its 8 neighbours (0..8, 4-bit sum).
  - Live cell with 2 or 3 live neighbours survives.
  - Dead cell with exactly 3 live neighbours is born.
  - All other cells become or stay dead.
  - Off-grid neighbours read as 0 (default edge handling).
- All cells update on the same clock edge; next state is computed only from the registered cells.
- A step commits: cells <= next, generation <= generation + 1 (saturating), stable <= (next == cells), and step_done pulses the following cycle.
- Tick counter:
  - Increments only in RUNNING; cleared to 0 on entering RUNNING.
  - A step commits on the edge ending the cycle where counter == TICK_DIV-1; the counter then wraps to 0.
  - With TICK_DIV = 1, RUNNING steps every cycle.
- PAUSED:
  - run = 1 -> RUNNING next cycle.
  - A step_req rising edge, detected against a registered copy of step_req, commits exactly one step on that edge's clock.
  - Holding step_req high gives no further steps.
- RUNNING:
  - run = 0 -> PAUSED; the tick counter holds at 0.
  - After a step, if AUTO_HALT and (next == cells, or next == 0) -> HALTED on the same edge.
- HALTED:
  - No steps; step_req is ignored.
  - run = 0 -> PAUSED; load -> PAUSED.
- Loading an all-zero pattern gives extinct = 1 immediately; no halt occurs until a step is taken.
- Elaboration errors: ROWS < 3, COLS < 3, or TICK_DIV < 1.

Optional Feature:
- Macro: LIFE_TOROIDAL_EN.
- Defined: edges wrap.
  - Row -1 maps to ROWS-1 and row ROWS maps to 0.
  - Column -1 maps to COLS-1 and column COLS maps to 0.
  - Corner neighbours wrap both ways.
- Undefined: off-grid neighbours are constant 0 (dead border); no wrap logic is generated.

Test Plan:
- Reset state: assert rst 2 cycles -> cells = 0, generation = 0, mode = 0, step_done = 0, stable = 0, extinct = 1.
- Single step, 5x5 default: load bits {11,12,13}, then a step_req pulse -> cells = bits {7,12,17}, generation = 1, step_done high 1 cycle. Hold step_req high 10 cycles -> no further change.
- Still life, TICK_DIV = 4: load 2x2 block at bits {6,7,11,12}, then run = 1.
  - First step commits after 4 cycles in RUNNING; stable = 1, mode = 2, generation = 1.
  - Later cycles -> no more steps.
- Extinction: load single cell bit 12, run = 1, TICK_DIV = 1 -> cells = 0, extinct = 1, mode = 2 after 1 step.
- AUTO_HALT = 0, blinker, TICK_DIV = 1, run = 1 for 6 cycles -> cells alternate {11,12,13} and {7,12,17}, generation = 6.
  - Assert load in cycle 3 -> generation = 0, mode = 0, cells = init_cells.
- Edges: load bits {1,2,3} (row 0), then step_req.
  - Without LIFE_TOROIDAL_EN -> cells = {2,7}.
  - With LIFE_TOROIDAL_EN -> cells = {2,7,22}.
